// File: rtl/p3_pkg.sv
// p3_pkg: shared types for the packet-buffer ownership scheduler.
//   buf_id_t    - 2-bit buffer select (00 none, 01 ping, 10 pang, 11 pung)
//   buf_state_t - lifecycle state of one packet buffer
package p3_pkg;

  typedef logic [1:0] buf_id_t;

  localparam buf_id_t BUF_NONE = 2'b00;
  localparam buf_id_t BUF_PING = 2'b01;
  localparam buf_id_t BUF_PANG = 2'b10;
  localparam buf_id_t BUF_PUNG = 2'b11;

  typedef enum logic [2:0] {
    ST_FREE,
    ST_FILL,
    ST_READY,
    ST_CPU,
    ST_ACC,
    ST_FWD
  } buf_state_t;

endpackage

// File: rtl/p3_idq.sv
// p3_idq: 3-entry FIFO of buffer IDs. Used to keep packets in arrival order
// between pipeline agents (ready queue and accept queue).
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push, din       - write din at the tail
//   pop             - drop the head entry
//   dout            - current head entry (valid when !empty)
//   empty, full     - occupancy flags
module p3_idq
  import p3_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  buf_id_t din,
  input  logic    pop,
  output buf_id_t dout,
  output logic    empty,
  output logic    full
);

  buf_id_t    mem [0:2];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [1:0] count;

  // Pointers wrap at 2 because the queue has three slots.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Storage, pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 2'd0;
      for (int i = 0; i < 3; i++) mem[i] <= BUF_NONE;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head and flag decode.
  always_comb begin
    dout  = mem[rd_ptr];
    empty = (count == 2'd0);
    full  = (count == 2'd3);
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/p3_buf_sched.sv
// p3_buf_sched: hands each of the three packet buffers to the snooper, then
// the CPU, then the forwarder, and back to the free pool, keeping packet
// order from snooper completion through forwarding.
// Optional feature: define P3_STATS_EN to add acc_cnt/rej_cnt/fwd_cnt.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   sn_done                   - snooper finished filling its buffer
//   cpu_acc, cpu_rej          - CPU verdict on its buffer (both = reject)
//   fwd_done                  - forwarder finished reading its buffer
//   sn_sel, cpu_sel, fwd_sel  - registered buffer selects (00 = none)
//   sn_stall                  - registered: snooper idle and nothing free
//   acc_cnt, rej_cnt, fwd_cnt - 32-bit event counters (P3_STATS_EN only)
module p3_buf_sched
  import p3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sn_done,
  input  logic        cpu_acc,
  input  logic        cpu_rej,
  input  logic        fwd_done,
  output logic [1:0]  sn_sel,
  output logic [1:0]  cpu_sel,
  output logic [1:0]  fwd_sel,
  output logic        sn_stall
`ifdef P3_STATS_EN
  ,
  output logic [31:0] acc_cnt,
  output logic [31:0] rej_cnt,
  output logic [31:0] fwd_cnt
`endif
);

  buf_state_t st_q   [1:3];
  buf_state_t st_nxt [1:3];

  buf_id_t sn_q, cpu_q, fwd_q;
  buf_id_t sn_nxt, cpu_nxt, fwd_nxt;
  logic    stall_q, stall_nxt;
  logic    sn_found;
  logic    any_free;

  logic    sn_rel, cpu_rel, fwd_rel;

  logic    rdy_push, rdy_pop, rdy_empty, rdy_full;
  logic    acc_push, acc_pop, acc_empty, acc_full;
  buf_id_t rdy_din, rdy_head, acc_din, acc_head;

  // Strobes only count when the agent actually owns a buffer.
  assign sn_rel  = sn_done && (sn_q != BUF_NONE);
  assign cpu_rel = (cpu_acc || cpu_rej) && (cpu_q != BUF_NONE);
  assign fwd_rel = fwd_done && (fwd_q != BUF_NONE);

  p3_idq u_rdy_q (
    .clk   (clk),
    .rst   (rst),
    .push  (rdy_push),
    .din   (rdy_din),
    .pop   (rdy_pop),
    .dout  (rdy_head),
    .empty (rdy_empty),
    .full  (rdy_full)
  );

  p3_idq u_acc_q (
    .clk   (clk),
    .rst   (rst),
    .push  (acc_push),
    .din   (acc_din),
    .pop   (acc_pop),
    .dout  (acc_head),
    .empty (acc_empty),
    .full  (acc_full)
  );

  // Next-state: each agent either releases its buffer or, when idle at this
  // edge, takes a new one. Grants look only at registered state, so a buffer
  // released at this edge is not handed on until the following edge.
  always_comb begin
    for (int i = 1; i <= 3; i++) st_nxt[i] = st_q[i];
    sn_nxt    = sn_q;
    cpu_nxt   = cpu_q;
    fwd_nxt   = fwd_q;
    rdy_push  = 1'b0;
    rdy_pop   = 1'b0;
    rdy_din   = BUF_NONE;
    acc_push  = 1'b0;
    acc_pop   = 1'b0;
    acc_din   = BUF_NONE;
    sn_found  = 1'b0;
    any_free  = 1'b0;
    stall_nxt = 1'b0;

    if (sn_rel) begin
      st_nxt[sn_q] = ST_READY;
      rdy_push     = 1'b1;
      rdy_din      = sn_q;
      sn_nxt       = BUF_NONE;
    end else if (sn_q == BUF_NONE) begin
      for (int i = 1; i <= 3; i++) begin
        if (!sn_found && st_q[i] == ST_FREE) begin
          sn_found  = 1'b1;
          st_nxt[i] = ST_FILL;
          sn_nxt    = buf_id_t'(i);
        end
      end
    end

    if (cpu_rel) begin
      if (cpu_rej) begin
        st_nxt[cpu_q] = ST_FREE;
      end else begin
        st_nxt[cpu_q] = ST_ACC;
        acc_push      = 1'b1;
        acc_din       = cpu_q;
      end
      cpu_nxt = BUF_NONE;
    end else if (cpu_q == BUF_NONE && !rdy_empty) begin
      rdy_pop          = 1'b1;
      st_nxt[rdy_head] = ST_CPU;
      cpu_nxt          = rdy_head;
    end

    if (fwd_rel) begin
      st_nxt[fwd_q] = ST_FREE;
      fwd_nxt       = BUF_NONE;
    end else if (fwd_q == BUF_NONE && !acc_empty) begin
      acc_pop          = 1'b1;
      st_nxt[acc_head] = ST_FWD;
      fwd_nxt          = acc_head;
    end

    for (int i = 1; i <= 3; i++) begin
      if (st_nxt[i] == ST_FREE) any_free = 1'b1;
    end
    stall_nxt = (sn_nxt == BUF_NONE) && !any_free;
  end

  // State register: buffer states, agent selects and the stall flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= 3; i++) st_q[i] <= ST_FREE;
      sn_q    <= BUF_NONE;
      cpu_q   <= BUF_NONE;
      fwd_q   <= BUF_NONE;
      stall_q <= 1'b0;
    end else begin
      for (int i = 1; i <= 3; i++) st_q[i] <= st_nxt[i];
      sn_q    <= sn_nxt;
      cpu_q   <= cpu_nxt;
      fwd_q   <= fwd_nxt;
      stall_q <= stall_nxt;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    sn_sel   = sn_q;
    cpu_sel  = cpu_q;
    fwd_sel  = fwd_q;
    sn_stall = stall_q;
  end

`ifdef P3_STATS_EN
  // Event counters; a simultaneous accept and reject counts as a reject.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt <= 32'd0;
      rej_cnt <= 32'd0;
      fwd_cnt <= 32'd0;
    end else begin
      if (cpu_rel && !cpu_rej) acc_cnt <= acc_cnt + 32'd1;
      if (cpu_rel && cpu_rej)  rej_cnt <= rej_cnt + 32'd1;
      if (fwd_rel)             fwd_cnt <= fwd_cnt + 32'd1;
    end
  end
`endif

  a_rdy_no_overflow: assert property (@(posedge clk) disable iff (rst) !(rdy_push && rdy_full));
  a_acc_no_overflow: assert property (@(posedge clk) disable iff (rst) !(acc_push && acc_full));
  a_sel_distinct: assert property (@(posedge clk) disable iff (rst)
    !((sn_q != BUF_NONE && (sn_q == cpu_q || sn_q == fwd_q)) ||
      (cpu_q != BUF_NONE && cpu_q == fwd_q)));

endmodule
